// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue scheduler: opcode encodings,
// legality check and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_INC = 4'b1101;
  localparam logic [3:0] OP_DEC = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC,
      OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Round-robin scheduler sharing one combinational ALU between NREQ
// requesters; one operation in flight, response returned with requester ID.
module alu_issue_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic              alu_status,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_cout,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              rsp_illegal
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0] pend_id_q, pend_id_d;
  logic           alu_status_q, alu_status_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]     alu_opcode_q, alu_opcode_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_cout_q, rsp_cout_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_illegal_q, rsp_illegal_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic [3:0]      sel_op;
  logic            handshake;
  logic            illegal;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are only offered in IDLE, and never while reset is held.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign handshake = |req_ready;
  assign illegal   = !is_legal_op(alu_opcode_q);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
        sel_op = req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    pend_id_d     = pend_id_q;
    alu_status_d  = alu_status_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_opcode_d  = alu_opcode_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_cout_d    = rsp_cout_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          alu_a_d      = sel_a;
          alu_b_d      = sel_b;
          alu_opcode_d = sel_op;
          pend_id_d    = IDW'(grant_idx);
          ptr_d        = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
          alu_status_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Illegal ops still go to the ALU, but its outputs are discarded.
        alu_status_d  = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_id_d      = pend_id_q;
        rsp_result_d  = illegal ? '0 : alu_result;
        rsp_cout_d    = illegal ? 1'b0 : alu_cout;
        rsp_ovf_d     = illegal ? 1'b0 : alu_ovf;
        rsp_illegal_d = illegal;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        alu_status_d = 1'b0;
        rsp_valid_d  = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      pend_id_q     <= '0;
      alu_status_q  <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_opcode_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      rsp_cout_q    <= 1'b0;
      rsp_ovf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pend_id_q     <= pend_id_d;
      alu_status_q  <= alu_status_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_opcode_q  <= alu_opcode_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_cout_q    <= rsp_cout_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign alu_status  = alu_status_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_cout    = rsp_cout_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched: directed ops push expected grants
// and responses; a negedge monitor checks grants, responses and timing.
module tb_alu_issue_sched;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic              alu_status;
  logic [W-1:0]      alu_a, alu_b;
  logic [3:0]        alu_opcode;
  logic [W-1:0]      alu_result;
  logic              alu_cout, alu_ovf;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_cout, rsp_ovf, rsp_illegal;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   result;
    logic           cout;
    logic           ovf;
    logic           illegal;
  } rsp_t;

  rsp_t sb[$];
  int   grant_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   hs_count = 0;
  int   hs_target = 0;
  int   last_hs_cycle = 0;
  int   status_run = 0;
  logic prev_rsp_valid = 1'b0;
  logic prev_accept = 1'b0;

  alu_issue_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .alu_status  (alu_status),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .alu_ovf     (alu_ovf),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_cout    (rsp_cout),
    .rsp_ovf     (rsp_ovf),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Stand-in for the shared ALU; illegal codes yield junk the DUT must zero.
  logic [W:0] alu_tmp;
  always_comb begin
    alu_tmp    = '0;
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        alu_tmp    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_tmp[W-1:0];
        alu_cout   = alu_tmp[W];
        alu_ovf    = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      OP_SUB: begin
        alu_tmp    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_tmp[W-1:0];
        alu_cout   = alu_tmp[W];
        alu_ovf    = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      OP_INC: begin
        alu_tmp    = {1'b0, alu_a} + 1'b1;
        alu_result = alu_tmp[W-1:0];
        alu_cout   = alu_tmp[W];
        alu_ovf    = (alu_a == {1'b0, {(W-1){1'b1}}});
      end
      OP_DEC: begin
        alu_result = alu_a - 1'b1;
        alu_cout   = (alu_a == '0);
        alu_ovf    = (alu_a == {1'b1, {(W-1){1'b0}}});
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOT:  alu_result = ~alu_a;
      default: begin
        alu_result = alu_a ^ alu_b ^ 32'h0000_DEAD;
        alu_cout   = 1'b1;
        alu_ovf    = 1'b1;
      end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, "_req_ready"},   64'(req_ready),   0);
    check({tag, "_rsp_valid"},   64'(rsp_valid),   0);
    check({tag, "_alu_status"},  64'(alu_status),  0);
    check({tag, "_alu_a"},       64'(alu_a),       0);
    check({tag, "_alu_b"},       64'(alu_b),       0);
    check({tag, "_alu_opcode"},  64'(alu_opcode),  0);
    check({tag, "_rsp_id"},      64'(rsp_id),      0);
    check({tag, "_rsp_result"},  64'(rsp_result),  0);
    check({tag, "_rsp_flags"},   64'({rsp_cout, rsp_ovf, rsp_illegal}), 0);
  endtask

  task automatic apply_stimulus(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [3:0] op);
    req_a[r*W +: W]  = a;
    req_b[r*W +: W]  = b;
    req_op[r*4 +: 4] = op;
    req_valid[r]     = 1'b1;
  endtask

  task automatic expect_rsp(input int g, input logic [W-1:0] res, input logic c,
                            input logic v, input logic ill);
    rsp_t e;
    e.id      = IDW'(g);
    e.result  = res;
    e.cout    = c;
    e.ovf     = v;
    e.illegal = ill;
    grant_q.push_back(g);
    sb.push_back(e);
  endtask

  // Returns at #1 after the edge that completes the awaited handshake.
  task automatic wait_hs(input int n, input string name);
    int budget = 0;
    hs_target += n;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (hs_count < hs_target && budget < 200);
    check({name, "_hs_timeout"}, 64'(hs_count >= hs_target), 1);
  endtask

  task automatic wait_drain(input string name);
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check({name, "_drain_timeout"}, 64'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    logic [NREQ-1:0] hs;
    int              idx;
    rsp_t            e;
    hs = req_valid & req_ready;
    if (req_ready != '0) begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 1);
      check("ready_only_in_idle", 64'(rsp_valid | alu_status), 0);
    end
    if (prev_accept && !rst && req_valid != '0)
      check("regrant_next_cycle", 64'(|req_ready), 1);
    if (hs != '0) begin
      idx = hs[1] ? 1 : 0;
      if (grant_q.size() == 0) begin
        check("grant_unexpected", 64'(idx), 64'hFF);
      end else begin
        check("grant_order", 64'(idx), 64'(grant_q[0]));
        void'(grant_q.pop_front());
      end
      hs_count++;
      last_hs_cycle = cycle;
    end
    if (rsp_valid) begin
      if (!prev_rsp_valid) check("latency", 64'(cycle - last_hs_cycle), 2);
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 0);
      end else begin
        e = sb[0];
        check("rsp_id",      64'(rsp_id),      64'(e.id));
        check("rsp_result",  64'(rsp_result),  64'(e.result));
        check("rsp_cout",    64'(rsp_cout),    64'(e.cout));
        check("rsp_ovf",     64'(rsp_ovf),     64'(e.ovf));
        check("rsp_illegal", 64'(rsp_illegal), 64'(e.illegal));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    if (alu_status) begin
      status_run++;
    end else begin
      if (status_run != 0) check("status_width", 64'(status_run), 1);
      status_run = 0;
    end
    prev_rsp_valid = rsp_valid;
    prev_accept    = rsp_valid & rsp_ready;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = '1;
    @(negedge clk);
    check_output("reset");
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;

    $display("[TB] single add");
    expect_rsp(0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    apply_stimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
    wait_hs(1, "add");
    req_valid = '0;
    wait_drain("add");

    $display("[TB] illegal opcode");
    expect_rsp(1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1, 32'd5, 32'd3, 4'b0011);
    wait_hs(1, "illegal");
    req_valid = '0;
    wait_drain("illegal");

    $display("[TB] round robin");
    for (int k = 0; k < 2; k++) begin
      expect_rsp(0, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
      expect_rsp(1, 32'hEDCB_A987, 1'b0, 1'b0, 1'b0);
    end
    apply_stimulus(0, 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND);
    apply_stimulus(1, 32'h1234_5678, 32'hFFFF_FFFF, OP_XOR);
    wait_hs(4, "rr");
    req_valid = '0;
    wait_drain("rr");

    $display("[TB] backpressure");
    expect_rsp(0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    apply_stimulus(0, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    wait_hs(1, "bp");
    req_valid = '0;
    rsp_ready = 1'b0;
    expect_rsp(1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1, 32'hFFFF_FFFF, 32'h0000_0000, OP_INC);
    begin
      int budget = 0;
      while (!rsp_valid && budget < 20) begin
        @(posedge clk);
        #1;
        budget++;
      end
      check("bp_rsp_timeout", 64'(rsp_valid), 1);
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_no_grant", 64'(req_ready), 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_hs(1, "bp_next");
    req_valid = '0;
    wait_drain("bp");

    $display("[TB] operand isolation");
    expect_rsp(0, 32'd7, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 32'd10, 32'd3, OP_SUB);
    wait_hs(1, "iso");
    req_a[0 +: W] = 32'd99;
    req_valid     = '0;
    wait_drain("iso");

    $display("[TB] mid-operation reset");
    expect_rsp(0, 32'd3, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 32'd1, 32'd2, OP_ADD);
    wait_hs(1, "midrst");
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check_output("midrst");
    @(posedge clk);
    #1;
    expect_rsp(0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1, 32'd3, 32'd3, OP_AND);
    apply_stimulus(0, 32'd0, 32'd0, OP_DEC);
    wait_hs(1, "postrst");
    req_valid = '0;
    wait_drain("postrst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
